// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_arbiter #(
    parameter int n = 64
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_ctrl,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_ctrl,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    output logic [n-1:0] alu_busA,
    output logic [n-1:0] alu_busB,
    output logic [3:0]   alu_ctrl,
    input  logic [n-1:0] alu_busW,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [n-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, stateNext;
    logic           lastGrant;
    logic [3:0]     ctrlQ;
    logic [n-1:0]   aQ, bQ;
    logic           idQ;
    logic [n-1:0]   dataQ;
    logic           zeroQ, errQ;

    logic           grant0, grant1, accept, winId;
    logic [3:0]     winCtrl;
    logic [n-1:0]   winA, winB;

    function automatic logic isLegal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // On a tie the requester that was not served last wins.
    assign grant0  = req0_valid && (!req1_valid || lastGrant);
    assign grant1  = req1_valid && (!req0_valid || !lastGrant);
    assign accept  = (state == IDLE) && (grant0 || grant1);
    assign winId   = grant1;
    assign winCtrl = grant1 ? req1_ctrl : req0_ctrl;
    assign winA    = grant1 ? req1_a : req0_a;
    assign winB    = grant1 ? req1_b : req0_b;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            ctrlQ     <= '0;
            aQ        <= '0;
            bQ        <= '0;
            idQ       <= 1'b0;
            dataQ     <= '0;
            zeroQ     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                ctrlQ     <= winCtrl;
                aQ        <= winA;
                bQ        <= winB;
                idQ       <= winId;
                lastGrant <= winId;
                // Illegal codes skip EXEC, so the error response is formed here.
                errQ      <= !isLegal(winCtrl);
                if (!isLegal(winCtrl)) begin
                    dataQ <= '0;
                    zeroQ <= 1'b1;
                end
            end
            if (state == EXEC) begin
                dataQ <= alu_busW;
                zeroQ <= alu_zero;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = isLegal(winCtrl) ? EXEC : RESP;
            EXEC: stateNext = RESP;
            RESP: if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_busA   = '0;
        alu_busB   = '0;
        alu_ctrl   = 4'b0000;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
            end
            EXEC: begin
                alu_busA = aQ;
                alu_busB = bQ;
                alu_ctrl = ctrlQ;
            end
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_id   = idQ;
    assign rsp_data = dataQ;
    assign rsp_zero = zeroQ;
    assign rsp_err  = errQ;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model on the shared bus.
module tb_alu_arbiter;
    localparam int n = 64;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]   req0_ctrl, req1_ctrl, alu_ctrl;
    logic [n-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [n-1:0] alu_busA, alu_busB, alu_busW, rsp_data;
    logic         alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.n(n)) dut (
        .CLK(CLK), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_ctrl(alu_ctrl),
        .alu_busW(alu_busW), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Shared ALU model; MOVZ modelled as pass-B.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_busW = alu_busA & alu_busB;
            4'b0001: alu_busW = alu_busA | alu_busB;
            4'b0010: alu_busW = alu_busA + alu_busB;
            4'b0110: alu_busW = alu_busA - alu_busB;
            4'b0111: alu_busW = alu_busB;
            4'b1000: alu_busW = alu_busB;
            default: alu_busW = '0;
        endcase
        alu_zero = (alu_busW == '0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setReq0(input logic v, input logic [3:0] c, input logic [n-1:0] a, input logic [n-1:0] b);
        req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
    endtask

    task automatic setReq1(input logic v, input logic [3:0] c, input logic [n-1:0] a, input logic [n-1:0] b);
        req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        rsp_ready = 1'b0;
        setReq0(1'b0, 4'h0, '0, '0);
        setReq1(1'b0, 4'h0, '0, '0);
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (alu_busA !== '0 || alu_busB !== '0 || alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_alu got=%h %h %h exp=0", alu_busA, alu_busB, alu_ctrl); end
        checks++; if (rsp_data !== '0 || rsp_err !== 1'b0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h %b %b %b exp=0", rsp_data, rsp_err, rsp_zero, rsp_id); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        Reset = 1'b0;
    endtask

    task automatic test_single();
        setReq0(1'b1, 4'b0010, 64'd5, 64'd7);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || alu_busA !== 64'd5 || alu_busB !== 64'd7 || alu_ctrl !== 4'b0010) begin errors++; $display("FAIL single_exec got=%b %h %h %h exp=0 5 7 2", rsp_valid, alu_busA, alu_busB, alu_ctrl); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp got=%b %b %0d %b %b exp=1 0 12 0 0", rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err); end
        checks++; if (alu_busA !== '0 || alu_ctrl !== 4'h0) begin errors++; $display("FAIL single_alu_idle got=%h %h exp=0 0", alu_busA, alu_ctrl); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_tie();
        Reset = 1'b1; #2; Reset = 1'b0;
        setReq0(1'b1, 4'b0110, 64'd9, 64'd9);
        setReq1(1'b1, 4'b0001, 64'hF0, 64'h0F);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== '0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL tie_rsp0 got=%b %b %h %b exp=1 0 0 1", rsp_valid, rsp_id, rsp_data, rsp_zero); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL tie_idle got=%b %b exp=0 1", rsp_valid, req1_ready); end
        tick();
        req1_valid = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 64'hFF || rsp_zero !== 1'b0) begin errors++; $display("FAIL tie_rsp1 got=%b %b %h %b exp=1 1 ff 0", rsp_valid, rsp_id, rsp_data, rsp_zero); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic         expId[4];
        logic [n-1:0] expData[4];
        int k = 0;
        expId = '{1'b0, 1'b1, 1'b0, 1'b1};
        expData = '{64'd2, 64'd30, 64'd2, 64'd30};
        setReq0(1'b1, 4'b0010, 64'd1, 64'd1);
        setReq1(1'b1, 4'b0010, 64'd10, 64'd20);
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_id !== expId[k] || rsp_data !== expData[k]) begin
                    errors++; $display("FAIL b2b_grant%0d got=%b %0d exp=%b %0d", k, rsp_id, rsp_data, expId[k], expData[k]);
                end
                k++;
                if (k == 4) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
        end
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", k); end
        tick();
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        setReq1(1'b1, 4'b0111, 64'd3, 64'hABCD);
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 64'hABCD || rsp_err !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got=%b %b %h %b %b%b exp=1 1 abcd 0 00", i, rsp_valid, rsp_id, rsp_data, rsp_err, req0_ready, req1_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_release got=%b %b%b exp=0 10", rsp_valid, req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        setReq1(1'b1, 4'b0011, 64'd3, 64'd4);
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%b exp=1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL illegal_rsp got=%b %b %h %b %b exp=1 1 0 1 1", rsp_valid, rsp_err, rsp_data, rsp_zero, rsp_id); end
        checks++; if (alu_busA !== '0 || alu_busB !== '0 || alu_ctrl !== 4'h0) begin errors++; $display("FAIL illegal_alu got=%h %h %h exp=0", alu_busA, alu_busB, alu_ctrl); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        setReq1(1'b1, 4'b1000, 64'd0, 64'h1234_5678);
        tick();
        req1_valid = 1'b0;
        checks++; if (alu_busB !== 64'h1234_5678 || alu_ctrl !== 4'b1000) begin errors++; $display("FAIL mid_exec got=%h %h exp=12345678 8", alu_busB, alu_ctrl); end
        Reset = 1'b1; #1;
        checks++; if (alu_busB !== '0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async got=%h %b exp=0 0", alu_busB, rsp_valid); end
        #1; Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp got=%0d exp=0", seen); end
        setReq0(1'b1, 4'b0010, 64'd1, 64'd2);
        setReq1(1'b1, 4'b0010, 64'd4, 64'd4);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_prio got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'd3) begin errors++; $display("FAIL mid_next got=%b %b %0d exp=1 0 3", rsp_valid, rsp_id, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
